// File: rtl/abc_sweep_ctrl.sv
// abc_sweep_ctrl: clocked sequencer/checker that sweeps {a,b,c}=0..7 into the circuit under test
// and checks d=(a&b)|~c, e=~c. Build macro SWEEP_LOOP_EN: sweep repeats until abort (no DONE state).
module abc_sweep_ctrl #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [2:0]       abc_o,
  input  logic             d_i,
  input  logic             e_i,
  output logic             busy,
  output logic             done,
  output logic             err_flag,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       first_err_vec
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0]       HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1'b1);
  localparam logic [ERR_W-1:0] ERR_ZERO  = {ERR_W{1'b0}};

  function automatic logic golden_d(input logic [2:0] abc);
    golden_d = (abc[2] & abc[1]) | ~abc[0];
  endfunction

  function automatic logic golden_e(input logic [2:0] abc);
    golden_e = ~abc[0];
  endfunction

  state_t           state_r, state_nx_s;
  logic [2:0]       vec_r, vec_nx_s;
  logic [3:0]       hold_r, hold_nx_s;
  logic             busy_r, busy_nx_s;
  logic             done_r, done_nx_s;
  logic             err_flag_r, err_flag_nx_s;
  logic [ERR_W-1:0] err_cnt_r, err_cnt_nx_s;
  logic [2:0]       first_err_r, first_err_nx_s;
  logic             mismatch_s;

  // Compare the circuit response against the golden function of the vector currently driven
  always_comb begin
    mismatch_s = (d_i != golden_d(vec_r)) || (e_i != golden_e(vec_r));
  end

  // Next-state and next-output logic for the sweep sequencer
  always_comb begin
    state_nx_s     = state_r;
    vec_nx_s       = vec_r;
    hold_nx_s      = hold_r;
    done_nx_s      = 1'b0;
    err_flag_nx_s  = err_flag_r;
    err_cnt_nx_s   = err_cnt_r;
    first_err_nx_s = first_err_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !abort) begin
          state_nx_s     = ST_DRIVE;
          vec_nx_s       = 3'd0;
          hold_nx_s      = 4'd0;
          err_flag_nx_s  = 1'b0;
          err_cnt_nx_s   = ERR_ZERO;
          first_err_nx_s = 3'd0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (abort) begin
          state_nx_s = ST_IDLE;
          vec_nx_s   = 3'd0;
          hold_nx_s  = 4'd0;
        end else if (hold_r == HOLD_LAST) begin
          state_nx_s = ST_SAMPLE;
          hold_nx_s  = 4'd0;
        end else begin
          hold_nx_s = hold_r + 4'd1;
        end
      end
      ST_SAMPLE: begin
        // An aborted sample is discarded, so a mismatch seen here is not recorded
        if (abort) begin
          state_nx_s = ST_IDLE;
          vec_nx_s   = 3'd0;
          hold_nx_s  = 4'd0;
        end else begin
          if (mismatch_s) begin
            if (err_cnt_r != ERR_MAX) begin
              err_cnt_nx_s = err_cnt_r + ERR_ONE;
            end else begin
              err_cnt_nx_s = err_cnt_r;
            end
            if (!err_flag_r) begin
              err_flag_nx_s  = 1'b1;
              first_err_nx_s = vec_r;
            end else begin
              first_err_nx_s = first_err_r;
            end
          end else begin
            err_cnt_nx_s = err_cnt_r;
          end
          if (vec_r != 3'd7) begin
            state_nx_s = ST_DRIVE;
            vec_nx_s   = vec_r + 3'd1;
          end else begin
`ifdef SWEEP_LOOP_EN
            state_nx_s = ST_DRIVE;
            vec_nx_s   = 3'd0;
            done_nx_s  = 1'b1;
`else
            state_nx_s = ST_DONE;
            done_nx_s  = 1'b1;
`endif
          end
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
        vec_nx_s   = 3'd0;
        hold_nx_s  = 4'd0;
      end
      default: begin
        state_nx_s = ST_IDLE;
        vec_nx_s   = 3'd0;
        hold_nx_s  = 4'd0;
      end
    endcase
    busy_nx_s = (state_nx_s == ST_DRIVE) || (state_nx_s == ST_SAMPLE);
  end

  // State, vector, hold counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      vec_r       <= 3'd0;
      hold_r      <= 4'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_flag_r  <= 1'b0;
      err_cnt_r   <= ERR_ZERO;
      first_err_r <= 3'd0;
    end else begin
      state_r     <= state_nx_s;
      vec_r       <= vec_nx_s;
      hold_r      <= hold_nx_s;
      busy_r      <= busy_nx_s;
      done_r      <= done_nx_s;
      err_flag_r  <= err_flag_nx_s;
      err_cnt_r   <= err_cnt_nx_s;
      first_err_r <= first_err_nx_s;
    end
  end

  assign abc_o         = vec_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err_flag      = err_flag_r;
  assign err_cnt       = err_cnt_r;
  assign first_err_vec = first_err_r;

endmodule
